// File: rtl/array_drain_pkg.sv
// Shared constants and state encoding for the accumulator drain block.
`default_nettype none

package array_drain_pkg;

  localparam int DEF_LANES = 64;
  localparam int DEF_IDX_W = 6;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/array_drain_pick.sv
// Priority search: lowest lane index >= from whose nonzero flag is set.
`default_nettype none

module array_drain_pick #(
  parameter int LANES = 64,
  parameter int IW    = 6
) (
  input  logic [LANES-1:0] nz,
  input  logic [IW:0]      from,
  output logic             found,
  output logic [IW-1:0]    idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (nz[i] && ((IW + 1)'(i) >= from)) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/param_def.sv
// Shared datapath width definitions for the MAC array and its drain logic.
`ifndef MAC_BW
`define MAC_BW 16
`endif

// File: rtl/array_drain.sv
// Snapshots LANES accumulator values on iStart and streams them out one lane per beat.
// Optional feature: define ARRAY_DRAIN_SKIP_ZERO_EN to skip lanes whose snapshot is zero.
`default_nettype none

`ifndef MAC_BW
`include "param_def.sv"
`endif

module array_drain
  import array_drain_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int BW    = `MAC_BW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2*BW-1:0]            iC [LANES],
  input  logic                       iStart,
  output logic                       oBusy,
  output logic                       oValid,
  input  logic                       iReady,
  output logic [2*BW-1:0]            oData,
  output logic [$clog2(LANES)-1:0]   oIdx,
  output logic                       oLast,
  output logic                       oDone
);

  localparam int IW = $clog2(LANES);

  state_t            state, state_nx;
  logic [IW-1:0]     idx;
  logic              done;
  logic [2*BW-1:0]   snap [LANES];

  logic              start_ok;
  logic              xfer;
  logic              first_found;
  logic [IW-1:0]     first_idx;
  logic [IW-1:0]     next_idx;
  logic              is_last;

  assign start_ok = (state == IDLE) && iStart;
  assign xfer     = (state == SEND) && iReady;

`ifdef ARRAY_DRAIN_SKIP_ZERO_EN
  logic [LANES-1:0] in_nz;
  logic [LANES-1:0] snap_nz;
  logic [IW:0]      next_from;
  logic             next_found;

  always_comb begin
    in_nz   = '0;
    snap_nz = '0;
    for (int i = 0; i < LANES; i++) begin
      in_nz[i]   = |iC[i];
      snap_nz[i] = |snap[i];
    end
  end

  assign next_from = {1'b0, idx} + (IW + 1)'(1);

  // The first beat is searched in the live inputs since the snapshot loads on the same edge.
  array_drain_pick #(.LANES(LANES), .IW(IW)) u_pick_first (
    .nz    (in_nz),
    .from  ('0),
    .found (first_found),
    .idx   (first_idx)
  );

  array_drain_pick #(.LANES(LANES), .IW(IW)) u_pick_next (
    .nz    (snap_nz),
    .from  (next_from),
    .found (next_found),
    .idx   (next_idx)
  );

  assign is_last = !next_found;
`else
  assign first_found = 1'b1;
  assign first_idx   = '0;
  assign next_idx    = idx + IW'(1);
  assign is_last     = (idx == IW'(LANES - 1));
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (iStart && first_found) state_nx = SEND;
      SEND: if (iReady && is_last)     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= '0;
      done <= 1'b0;
      for (int i = 0; i < LANES; i++) snap[i] <= '0;
    end else begin
      done <= (xfer && is_last) || (start_ok && !first_found);
      if (start_ok) begin
        idx <= first_idx;
        for (int i = 0; i < LANES; i++) snap[i] <= iC[i];
      end else if (xfer) begin
        idx <= is_last ? '0 : next_idx;
      end
    end
  end

  assign oBusy  = (state == SEND);
  assign oValid = (state == SEND);
  assign oLast  = (state == SEND) && is_last;
  assign oIdx   = idx;
  assign oData  = snap[idx];
  assign oDone  = done;

endmodule

`default_nettype wire

// File: tb/tb_array_drain.sv
// Directed self-checking bench for array_drain (64 lanes, 32-bit lane results).
`default_nettype none

module tb_array_drain;

  localparam int LANES = 64;
  localparam int BW    = 16;
  localparam int DW    = 2 * BW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] c [LANES];
  logic          start = 1'b0;
  logic          ready = 1'b0;
  logic          busy, valid, last, done;
  logic [DW-1:0] data;
  logic [5:0]    idx;

  int n_cmp  = 0;
  int n_fail = 0;

  // Packed view: {valid, busy, last, done, idx, data}
  logic [41:0] obs;
  logic [41:0] want;
  assign obs = {valid, busy, last, done, idx, data};

  always #5 clk = ~clk;

  array_drain #(.LANES(LANES), .BW(BW)) dut (
    .clk    (clk),
    .rst    (rst),
    .iC     (c),
    .iStart (start),
    .oBusy  (busy),
    .oValid (valid),
    .iReady (ready),
    .oData  (data),
    .oIdx   (idx),
    .oLast  (last),
    .oDone  (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < LANES; i++) c[i] = DW'(i + 1);
    #3;
    want = '0;
    n_cmp++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h", obs, want);
    end
    step();
    step();
    rst = 1'b0;
    step();
    want = '0;
    n_cmp++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %h want %h", obs, want);
    end
  endtask

  task automatic test_full_drain();
    for (int i = 0; i < LANES; i++) c[i] = DW'(i + 1);
    ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int b = 0; b < LANES; b++) begin
      want = {1'b1, 1'b1, (b == LANES - 1), 1'b0, 6'(b), DW'(b + 1)};
      n_cmp++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL full_beat%0d: got %h want %h", b, obs, want);
      end
      step();
    end
    want = {1'b0, 1'b0, 1'b0, 1'b1, 6'd0, DW'(1)};
    n_cmp++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL full_done: got %h want %h", obs, want);
    end
    step();
    n_cmp++;
    if (done !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_done_width: got done=%b valid=%b want done=0 valid=0", done, valid);
    end
    ready = 1'b0;
  endtask

  task automatic test_stall();
    int  expn = 0;
    int  cyc  = 0;
    logic rdy = 1'b0;
    for (int i = 0; i < LANES; i++) c[i] = DW'(32'hA000_0000 + i * 3);
    start = 1'b1;
    step();
    start = 1'b0;
    while (expn < LANES && cyc < 300) begin
      want = {1'b1, 1'b1, (expn == LANES - 1), 1'b0, 6'(expn), DW'(32'hA000_0000 + expn * 3)};
      n_cmp++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL stall_beat%0d_cyc%0d: got %h want %h", expn, cyc, obs, want);
      end
      ready = rdy;
      step();
      if (rdy) expn++;
      rdy = !rdy;
      cyc++;
    end
    n_cmp++;
    if (expn != LANES || done !== 1'b1 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_end: got beats=%0d done=%b valid=%b want beats=64 done=1 valid=0",
               expn, done, valid);
    end
    ready = 1'b0;
    step();
  endtask

  task automatic test_recapture();
    for (int i = 0; i < LANES; i++) c[i] = DW'(i * 7 + 5);
    ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int b = 0; b < LANES; b++) begin
      if (b == 5) begin
        for (int i = 0; i < LANES; i++) c[i] = '1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      want = {1'b1, 1'b1, (b == LANES - 1), 1'b0, 6'(b), DW'(b * 7 + 5)};
      n_cmp++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL recap_beat%0d: got %h want %h", b, obs, want);
      end
      step();
    end
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL recap_done: got done=%b valid=%b want done=1 valid=0", done, valid);
    end
    ready = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < LANES; i++) c[i] = DW'(i + 1000);
    ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int b = 0; b < 10; b++) step();
    want = {1'b1, 1'b1, 1'b0, 1'b0, 6'd10, DW'(1010)};
    n_cmp++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL rstmid_beat10: got %h want %h", obs, want);
    end
    #2;
    rst = 1'b1;
    #1;
    want = '0;
    n_cmp++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL rstmid_async: got %h want %h", obs, want);
    end
    step();
    rst = 1'b0;
    step();
    n_cmp++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL rstmid_no_resume: got %h want %h", obs, want);
    end
    for (int i = 0; i < LANES; i++) c[i] = DW'(i + 500);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int b = 0; b < LANES; b++) begin
      want = {1'b1, 1'b1, (b == LANES - 1), 1'b0, 6'(b), DW'(b + 500)};
      n_cmp++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL rstmid_redrain%0d: got %h want %h", b, obs, want);
      end
      step();
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_done: got %b want 1", done);
    end
    ready = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < LANES; i++) c[i] = DW'(i + 1);
    ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int b = 0; b < LANES; b++) step();
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done: got done=%b busy=%b want done=1 busy=0", done, busy);
    end
    for (int i = 0; i < LANES; i++) c[i] = DW'(i + 200);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int b = 0; b < LANES; b++) begin
      want = {1'b1, 1'b1, (b == LANES - 1), 1'b0, 6'(b), DW'(b + 200)};
      n_cmp++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL b2b_beat%0d: got %h want %h", b, obs, want);
      end
      step();
    end
    ready = 1'b0;
    step();
  endtask

`ifdef ARRAY_DRAIN_SKIP_ZERO_EN
  task automatic test_skip_zero();
    for (int i = 0; i < LANES; i++) c[i] = '0;
    c[3]  = DW'(32'h0000_00AA);
    c[40] = DW'(32'h0000_00BB);
    ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    want = {1'b1, 1'b1, 1'b0, 1'b0, 6'd3, DW'(32'hAA)};
    n_cmp++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL skip_lane3: got %h want %h", obs, want);
    end
    step();
    want = {1'b1, 1'b1, 1'b1, 1'b0, 6'd40, DW'(32'hBB)};
    n_cmp++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL skip_lane40: got %h want %h", obs, want);
    end
    step();
    n_cmp++;
    if (done !== 1'b1 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL skip_done: got done=%b valid=%b want done=1 valid=0", done, valid);
    end
    step();
    for (int i = 0; i < LANES; i++) c[i] = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL skip_allzero: got done=%b valid=%b busy=%b want 1/0/0", done, valid, busy);
    end
    step();
    n_cmp++;
    if (done !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL skip_allzero_after: got done=%b valid=%b want 0/0", done, valid);
    end
    ready = 1'b0;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < LANES; i++) c[i] = '0;
    test_reset();
    test_full_drain();
    test_stall();
    test_recapture();
    test_reset_mid();
    test_back_to_back();
`ifdef ARRAY_DRAIN_SKIP_ZERO_EN
    test_skip_zero();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
